// File: rtl/alu_input_loader_pkg.sv
// Shared constants for the ALU input loader: debounce state encoding,
// button indices and the ALU opcodes used by the top and its bench.
package alu_pkg;

    typedef enum logic [1:0] {
        DEB_IDLE      = 2'd0,
        DEB_PRESS_CNT = 2'd1,
        DEB_HELD      = 2'd2,
        DEB_REL_CNT   = 2'd3
    } deb_state_t;

    localparam int NUM_BTN = 3;
    localparam int BTN_A   = 0;
    localparam int BTN_B   = 1;
    localparam int BTN_OP  = 2;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu_input_loader_if.sv
// Board-side bundle of the loader: raw switches/buttons in, ALU operands out.
// The master side drives switches and buttons, the slave side is the loader.
interface alu_input_loader_if #(
    parameter int NB_DATA = 4,
    parameter int NB_OP   = 6,
    parameter int NB_SW   = 8
);
    logic        [NB_SW-1:0]   i_sw;
    logic        [2:0]         i_btn;
    logic signed [NB_DATA-1:0] o_datoA;
    logic signed [NB_DATA-1:0] o_datoB;
    logic        [NB_OP-1:0]   o_operation;
    logic                      o_valid;

    modport master (
        output i_sw,
        output i_btn,
        input  o_datoA,
        input  o_datoB,
        input  o_operation,
        input  o_valid
    );

    modport slave (
        input  i_sw,
        input  i_btn,
        output o_datoA,
        output o_datoB,
        output o_operation,
        output o_valid
    );
endinterface

// File: rtl/alu_input_loader_btn_debounce.sv
// One push-button path: 2-flop synchronizer, debounce FSM with a saturating
// stability counter, and a registered single-cycle pulse per accepted press.
module btn_debounce
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_meta_reg;
    logic             btn_sync_reg;
    deb_state_t       state_reg;
    deb_state_t       state_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             pulse_reg;
    logic             pulse_next;
    logic             count_done;

    assign count_done = (count_reg == CNT_LAST);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_meta_reg <= 1'b0;
            btn_sync_reg <= 1'b0;
            state_reg    <= DEB_IDLE;
            count_reg    <= '0;
            pulse_reg    <= 1'b0;
        end else begin
            btn_meta_reg <= i_btn;
            btn_sync_reg <= btn_meta_reg;
            state_reg    <= state_next;
            count_reg    <= count_next;
            pulse_reg    <= pulse_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DEB_IDLE:      if (btn_sync_reg) state_next = DEB_PRESS_CNT;
            DEB_PRESS_CNT: begin
                if (!btn_sync_reg)   state_next = DEB_IDLE;
                else if (count_done) state_next = DEB_HELD;
            end
            DEB_HELD:      if (!btn_sync_reg) state_next = DEB_REL_CNT;
            DEB_REL_CNT: begin
                if (btn_sync_reg)    state_next = DEB_HELD;
                else if (count_done) state_next = DEB_IDLE;
            end
            default:       state_next = DEB_IDLE;
        endcase
    end

    // The counter restarts from zero on every state change and stops at
    // CNT_LAST because reaching it always leaves the counting state.
    always_comb begin
        count_next = '0;
        pulse_next = 1'b0;
        case (state_reg)
            DEB_PRESS_CNT: begin
                if (btn_sync_reg && count_done) pulse_next = 1'b1;
                else if (btn_sync_reg)          count_next = count_reg + 1'b1;
            end
            DEB_REL_CNT: begin
                if (!btn_sync_reg && !count_done) count_next = count_reg + 1'b1;
            end
            default: count_next = '0;
        endcase
    end

    assign o_pulse = pulse_reg;

endmodule

// File: rtl/alu_input_loader.sv
// Captures the synchronized switches into operand A, operand B and the opcode
// on debounced button presses; o_valid flags that all three have been loaded.
module alu_input_loader
    import alu_pkg::*;
#(
    parameter int NB_DATA         = 4,
    parameter int NB_OP           = 6,
    parameter int NB_SW           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             i_rst_n,
    alu_input_loader_if.slave bus
);
    // Only the switch bits that some target register can take are synchronized.
    localparam int NB_MAX = (NB_DATA > NB_OP) ? NB_DATA : NB_OP;
    localparam int NB_CAP = (NB_MAX < NB_SW) ? NB_MAX : NB_SW;

    logic        [NB_CAP-1:0]  sw_meta_reg;
    logic        [NB_CAP-1:0]  sw_sync_reg;
    logic        [NUM_BTN-1:0] load_pulse;
    logic        [NUM_BTN-1:0] loaded_reg;
    logic signed [NB_DATA-1:0] dato_a_reg;
    logic signed [NB_DATA-1:0] dato_b_reg;
    logic        [NB_OP-1:0]   operation_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .i_rst_n(i_rst_n),
                .i_btn  (bus.i_btn[gi]),
                .o_pulse(load_pulse[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_meta_reg   <= '0;
            sw_sync_reg   <= '0;
            dato_a_reg    <= '0;
            dato_b_reg    <= '0;
            operation_reg <= '0;
            loaded_reg    <= '0;
        end else begin
            sw_meta_reg <= bus.i_sw[NB_CAP-1:0];
            sw_sync_reg <= sw_meta_reg;
            if (load_pulse[BTN_A])  dato_a_reg    <= sw_sync_reg[NB_DATA-1:0];
            if (load_pulse[BTN_B])  dato_b_reg    <= sw_sync_reg[NB_DATA-1:0];
            if (load_pulse[BTN_OP]) operation_reg <= sw_sync_reg[NB_OP-1:0];
            loaded_reg <= loaded_reg | load_pulse;
        end
    end

    assign bus.o_datoA     = dato_a_reg;
    assign bus.o_datoB     = dato_b_reg;
    assign bus.o_operation = operation_reg;
    assign bus.o_valid     = &loaded_reg;

endmodule

// File: tb/tb_alu_input_loader.sv
// Directed bench for alu_input_loader with a run-length model of the
// debounce rules, checked every cycle, plus hand-computed literal checks.
module tb_alu_input_loader;
    import alu_pkg::*;

    localparam int NB_DATA = 4;
    localparam int NB_OP   = 6;
    localparam int NB_SW   = 8;
    localparam int DEB     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_input_loader_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_SW(NB_SW)) bus ();

    alu_input_loader #(
        .NB_DATA        (NB_DATA),
        .NB_OP          (NB_OP),
        .NB_SW          (NB_SW),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk    (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    // Model: a press is accepted once the synchronized level (raw level two
    // samples late) has been high for DEB+1 consecutive edges while armed;
    // re-arming needs DEB+1 consecutive low edges. Capture follows one edge
    // later with the switch value sampled two edges before the capture.
    logic [NB_DATA-1:0] m_a      = '0;
    logic [NB_DATA-1:0] m_b      = '0;
    logic [NB_OP-1:0]   m_op     = '0;
    logic [2:0]         m_loaded = '0;
    logic [2:0]         btn_d1   = '0;
    logic [2:0]         btn_d2   = '0;
    logic [NB_SW-1:0]   sw_d1    = '0;
    logic [NB_SW-1:0]   sw_d2    = '0;
    int                 run_hi[3];
    int                 run_lo[3];
    bit                 armed[3];
    bit                 pend[3];

    task model_reset();
        m_a = '0; m_b = '0; m_op = '0; m_loaded = '0;
        btn_d1 = '0; btn_d2 = '0; sw_d1 = '0; sw_d2 = '0;
        for (int n = 0; n < 3; n++) begin
            run_hi[n] = 0; run_lo[n] = 0; armed[n] = 1'b1; pend[n] = 1'b0;
        end
    endtask

    task model_edge();
        if (pend[BTN_A])  m_a  = sw_d2[NB_DATA-1:0];
        if (pend[BTN_B])  m_b  = sw_d2[NB_DATA-1:0];
        if (pend[BTN_OP]) m_op = sw_d2[NB_OP-1:0];
        for (int n = 0; n < 3; n++) begin
            if (pend[n]) m_loaded[n] = 1'b1;
            if (btn_d2[n]) begin run_hi[n]++; run_lo[n] = 0; end
            else           begin run_lo[n]++; run_hi[n] = 0; end
            pend[n] = armed[n] && (run_hi[n] >= DEB + 1);
            if (pend[n])                                  armed[n] = 1'b0;
            else if (!armed[n] && run_lo[n] >= DEB + 1)   armed[n] = 1'b1;
        end
        btn_d2 = btn_d1; btn_d1 = bus.i_btn;
        sw_d2  = sw_d1;  sw_d1  = bus.i_sw;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_edge();
    end

    task automatic cmp(string name, logic [7:0] act, logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(string name, logic [7:0] act, logic [7:0] exp);
        if (act === exp) $display("ok   %s = %h", name, act);
        cmp(name, act, exp);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            cmp("cyc_datoA",     {4'b0, bus.o_datoA},     {4'b0, m_a});
            cmp("cyc_datoB",     {4'b0, bus.o_datoB},     {4'b0, m_b});
            cmp("cyc_operation", {2'b0, bus.o_operation}, {2'b0, m_op});
            cmp("cyc_valid",     {7'b0, bus.o_valid},     {7'b0, &m_loaded});
        end
    end

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(logic [2:0] mask, logic [7:0] sw, int hold);
        bus.i_sw = sw;
        wait_cycles(3);
        bus.i_btn = mask;
        wait_cycles(hold);
        bus.i_btn = 3'b000;
        wait_cycles(12);
    endtask

    initial begin
        bus.i_sw  = '0;
        bus.i_btn = '0;

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.i_sw  = 8'($urandom);
            bus.i_btn = 3'($urandom);
            if (i == 1) checking = 1'b1;
        end
        lit("rst_valid", {7'b0, bus.o_valid}, 8'h00);
        lit("rst_datoA", {4'b0, bus.o_datoA}, 8'h00);
        lit("rst_op",    {2'b0, bus.o_operation}, 8'h00);
        bus.i_sw  = '0;
        bus.i_btn = '0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(3);

        // Single load of A: update lands exactly at edge k+7
        bus.i_sw = 8'h05;
        wait_cycles(3);
        bus.i_btn = 3'b001;
        wait_cycles(7);
        lit("single_A_k6", {4'b0, bus.o_datoA}, 8'h00);
        wait_cycles(1);
        lit("single_A_k7", {4'b0, bus.o_datoA}, 8'h05);
        lit("single_valid", {7'b0, bus.o_valid}, 8'h00);
        bus.i_sw = 8'h0C;
        wait_cycles(5);
        bus.i_btn = 3'b000;
        wait_cycles(12);
        lit("single_A_once", {4'b0, bus.o_datoA}, 8'h05);

        // Full load; o_valid rises with the opcode update
        press(3'b001, 8'h03, 8);
        press(3'b010, 8'h0E, 8);
        bus.i_sw = 8'h20;
        wait_cycles(3);
        bus.i_btn = 3'b100;
        wait_cycles(7);
        lit("full_valid_k6", {7'b0, bus.o_valid}, 8'h00);
        wait_cycles(1);
        lit("full_valid_k7", {7'b0, bus.o_valid}, 8'h01);
        lit("full_op",   {2'b0, bus.o_operation}, {2'b0, OP_ADD});
        lit("full_A",    {4'b0, bus.o_datoA}, 8'h03);
        lit("full_B",    {4'b0, bus.o_datoB}, 8'h0E);
        bus.i_btn = 3'b000;
        wait_cycles(12);

        // Glitch rejection and the debounce-window boundary
        press(3'b010, 8'h05, 3);
        lit("glitch_B", {4'b0, bus.o_datoB}, 8'h0E);
        press(3'b100, 8'h11, 4);
        lit("short4_op", {2'b0, bus.o_operation}, 8'h20);
        press(3'b100, 8'h11, 5);
        lit("exact5_op", {2'b0, bus.o_operation}, 8'h11);

        // Long hold: one update only, later switch change ignored
        bus.i_sw = 8'h05;
        wait_cycles(3);
        bus.i_btn = 3'b010;
        wait_cycles(20);
        bus.i_sw = 8'h09;
        wait_cycles(30);
        bus.i_btn = 3'b000;
        wait_cycles(12);
        lit("hold50_B", {4'b0, bus.o_datoB}, 8'h05);
        lit("hold50_valid", {7'b0, bus.o_valid}, 8'h01);

        // Simultaneous press of all three buttons
        bus.i_sw = 8'h27;
        wait_cycles(3);
        bus.i_btn = 3'b111;
        wait_cycles(7);
        lit("simul_A_k6", {4'b0, bus.o_datoA}, 8'h03);
        wait_cycles(1);
        lit("simul_A",  {4'b0, bus.o_datoA}, 8'h07);
        lit("simul_B",  {4'b0, bus.o_datoB}, 8'h07);
        lit("simul_op", {2'b0, bus.o_operation}, {2'b0, OP_NOR});
        lit("simul_valid", {7'b0, bus.o_valid}, 8'h01);
        bus.i_btn = 3'b000;
        wait_cycles(12);

        // Reset during PRESS_CNT with the button still held
        bus.i_sw = 8'h0A;
        wait_cycles(3);
        bus.i_btn = 3'b001;
        wait_cycles(4);
        rst_n = 1'b0;
        #1;
        lit("midrst_A",     {4'b0, bus.o_datoA}, 8'h00);
        lit("midrst_valid", {7'b0, bus.o_valid}, 8'h00);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(7);
        lit("postrst_A_k6", {4'b0, bus.o_datoA}, 8'h00);
        wait_cycles(1);
        lit("postrst_A_k7", {4'b0, bus.o_datoA}, 8'h0A);
        lit("postrst_valid", {7'b0, bus.o_valid}, 8'h00);
        bus.i_btn = 3'b000;
        wait_cycles(12);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
